// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Front-end fetch stage. Owns the PC, runs a req/valid handshake
//             to instruction memory, assembles two-word instructions
//             (opword + 16-bit immediate) and presents them to decode.
//             Honours decode stall and jump redirect/flush.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000,
    parameter logic [4:0]            IMM_MASK     = 5'b11000,
    parameter logic [4:0]            IMM_MATCH    = 5'b11000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [15:0]           imem_data,
    input  logic                  imem_valid,
    input  logic                  stall,
    input  logic                  jump_taken,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic [15:0]           instruction,
    output logic [15:0]           immediate,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    localparam logic [ADDR_WIDTH-1:0] c_ONE = 1;

    typedef enum logic [0:0] {
        FETCH_OP  = 1'b0,
        FETCH_IMM = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           opword_q, opword_d;
    logic [15:0]           instruction_q, instruction_d;
    logic [15:0]           immediate_q, immediate_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
    logic [ADDR_WIDTH-1:0] next_pc_q, next_pc_d;

    logic w_free;
    logic w_xfer;
    logic w_two_word;

    // The output slot can take a new value when empty or when decode consumes it
    assign w_free     = !instr_valid_q || !stall;
    assign imem_req   = reset && w_free && !jump_taken;
    assign imem_addr  = pc_q;
    assign w_xfer     = imem_req && imem_valid;
    assign w_two_word = ((imem_data[15:11] & IMM_MASK) == IMM_MATCH);

    assign instruction = instruction_q;
    assign immediate   = immediate_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_out_q;
    assign next_pc     = next_pc_q;

    // Next-state: jump flush beats stall; a free slot without a finished
    // instruction becomes a bubble so decode never sees a value twice
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        opword_d      = opword_q;
        instruction_d = instruction_q;
        immediate_d   = immediate_q;
        instr_valid_d = instr_valid_q;
        pc_out_d      = pc_out_q;
        next_pc_d     = next_pc_q;
        if (jump_taken) begin
            pc_d          = jump_target;
            state_d       = FETCH_OP;
            instr_valid_d = 1'b0;
            opword_d      = 16'h0000;
        end else if (w_free) begin
            instr_valid_d = 1'b0;
            if (w_xfer) begin
                pc_d = pc_q + c_ONE;
                case (state_q)
                    FETCH_OP: begin
                        if (w_two_word) begin
                            opword_d = imem_data;
                            state_d  = FETCH_IMM;
                        end else begin
                            instruction_d = imem_data;
                            immediate_d   = 16'h0000;
                            pc_out_d      = pc_q;
                            next_pc_d     = pc_q + c_ONE;
                            instr_valid_d = 1'b1;
                        end
                    end
                    FETCH_IMM: begin
                        instruction_d = opword_q;
                        immediate_d   = imem_data;
                        pc_out_d      = pc_q - c_ONE;
                        next_pc_d     = pc_q + c_ONE;
                        instr_valid_d = 1'b1;
                        state_d       = FETCH_OP;
                    end
                    default: state_d = FETCH_OP;
                endcase
            end
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FETCH_OP;
            pc_q          <= RESET_VECTOR;
            opword_q      <= 16'h0000;
            instruction_q <= 16'h0000;
            immediate_q   <= 16'h0000;
            instr_valid_q <= 1'b0;
            pc_out_q      <= '0;
            next_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            opword_q      <= opword_d;
            instruction_q <= instruction_d;
            immediate_q   <= immediate_d;
            instr_valid_q <= instr_valid_d;
            pc_out_q      <= pc_out_d;
            next_pc_q     <= next_pc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        stall;
    logic        jump_taken;
    logic [15:0] jump_target;
    logic [15:0] instruction;
    logic [15:0] immediate;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic [15:0] next_pc;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: optional fixed wait states per request
    logic [15:0] mem [0:65535];
    logic        ws_mode;
    int          wait_n;
    int          wcnt;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!imem_req || imem_valid) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    assign imem_valid = ws_mode ? (wcnt == wait_n) : 1'b1;
    assign imem_data  = imem_valid ? mem[imem_addr] : 16'hDEAD;

    fetch_stage #(
        .ADDR_WIDTH  (16),
        .RESET_VECTOR(16'h0000),
        .IMM_MASK    (5'b11000),
        .IMM_MATCH   (5'b11000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .stall      (stall),
        .jump_taken (jump_taken),
        .jump_target(jump_target),
        .instruction(instruction),
        .immediate  (immediate),
        .instr_valid(instr_valid),
        .pc_out     (pc_out),
        .next_pc    (next_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_req: got valid=%b req=%b want 0/0", instr_valid, imem_req);
        end
        n_checks++;
        if (instruction !== 16'h0 || immediate !== 16'h0 || pc_out !== 16'h0 || next_pc !== 16'h0 || imem_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_fields: got instr=%h imm=%h pc_out=%h next=%h addr=%h want all 0",
                     instruction, immediate, pc_out, next_pc, imem_addr);
        end
    endtask

    task automatic test_one_word();
        logic [15:0] exp_i [0:3];
        exp_i[0] = 16'h0800; exp_i[1] = 16'h1000; exp_i[2] = 16'h2000; exp_i[3] = 16'h3000;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (instr_valid !== 1'b1 || instruction !== exp_i[k] || immediate !== 16'h0 ||
                pc_out !== 16'(k) || next_pc !== 16'(k + 1)) begin
                n_fail++;
                $display("FAIL one_word[%0d]: got v=%b i=%h imm=%h pc=%h nx=%h want 1 %h 0000 %h %h",
                         k, instr_valid, instruction, immediate, pc_out, next_pc, exp_i[k], 16'(k), 16'(k + 1));
            end
        end
    endtask

    task automatic test_two_word();
        tick();
        n_checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0005) begin
            n_fail++;
            $display("FAIL two_word_bubble: got v=%b addr=%h want 0 0005", instr_valid, imem_addr);
        end
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instruction !== 16'hC100 || immediate !== 16'h00AB ||
            pc_out !== 16'h0004 || next_pc !== 16'h0006) begin
            n_fail++;
            $display("FAIL two_word: got v=%b i=%h imm=%h pc=%h nx=%h want 1 C100 00AB 0004 0006",
                     instr_valid, instruction, immediate, pc_out, next_pc);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_req[%0d]: got req=%b want 0", k, imem_req);
            end
            tick();
            n_checks++;
            if (instr_valid !== 1'b1 || instruction !== 16'hC100 || immediate !== 16'h00AB ||
                pc_out !== 16'h0004 || next_pc !== 16'h0006 || imem_addr !== 16'h0006) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b i=%h imm=%h pc=%h nx=%h addr=%h want 1 C100 00AB 0004 0006 0006",
                         k, instr_valid, instruction, immediate, pc_out, next_pc, imem_addr);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instruction !== 16'h0400 || pc_out !== 16'h0006 || next_pc !== 16'h0007) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b i=%h pc=%h nx=%h want 1 0400 0006 0007",
                     instr_valid, instruction, pc_out, next_pc);
        end
    endtask

    task automatic test_jump();
        // opword C200 at 7 is taken; now sitting in the immediate fetch
        tick();
        jump_taken  = 1'b1;
        jump_target = 16'h0040;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_req: got req=%b want 0", imem_req);
        end
        tick();
        jump_taken = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0040) begin
            n_fail++;
            $display("FAIL jump_redirect: got v=%b addr=%h want 0 0040", instr_valid, imem_addr);
        end
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instruction !== 16'h0100 || immediate !== 16'h0000 ||
            pc_out !== 16'h0040 || next_pc !== 16'h0041) begin
            n_fail++;
            $display("FAIL jump_target: got v=%b i=%h imm=%h pc=%h nx=%h want 1 0100 0000 0040 0041",
                     instr_valid, instruction, immediate, pc_out, next_pc);
        end
    endtask

    task automatic test_wrap();
        jump_taken  = 1'b1;
        jump_target = 16'hFFFF;
        tick();
        jump_taken = 1'b0;
        tick();
        n_checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_addr: got v=%b addr=%h want 0 0000", instr_valid, imem_addr);
        end
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instruction !== 16'hC300 || immediate !== 16'h1234 ||
            pc_out !== 16'hFFFF || next_pc !== 16'h0001) begin
            n_fail++;
            $display("FAIL wrap: got v=%b i=%h imm=%h pc=%h nx=%h want 1 C300 1234 FFFF 0001",
                     instr_valid, instruction, immediate, pc_out, next_pc);
        end
    endtask

    task automatic test_waits_reset();
        reset = 1'b0;
        mem[0] = 16'h0800; mem[1] = 16'hC400; mem[2] = 16'h7777;
        ws_mode = 1'b1;
        wait_n  = 2;
        tick();
        reset = 1'b1;
        #1;
        // two wait cycles on address 0: request and address must hold
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold[%0d]: got req=%b addr=%h v=%b want 1 0000 0", k, imem_req, imem_addr, instr_valid);
            end
        end
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instruction !== 16'h0800 || imem_addr !== 16'h0001) begin
            n_fail++;
            $display("FAIL wait_first: got v=%b i=%h addr=%h want 1 0800 0001", instr_valid, instruction, imem_addr);
        end
        tick(); tick(); tick();
        n_checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0002 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_imm_phase: got v=%b addr=%h req=%b want 0 0002 1", instr_valid, imem_addr, imem_req);
        end
        tick();
        n_checks++;
        if (imem_addr !== 16'h0002) begin
            n_fail++;
            $display("FAIL wait_imm_stable: got addr=%h want 0002", imem_addr);
        end
        // asynchronous reset in the middle of the immediate wait
        reset = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || instr_valid !== 1'b0 || instruction !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset: got req=%b addr=%h v=%b i=%h want 0 0000 0 0000",
                     imem_req, imem_addr, instr_valid, instruction);
        end
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instruction !== 16'h0800 || immediate !== 16'h0000 || pc_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL restart: got v=%b i=%h imm=%h pc=%h want 1 0800 0000 0000",
                     instr_valid, instruction, immediate, pc_out);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[0] = 16'h0800; mem[1] = 16'h1000; mem[2] = 16'h2000; mem[3] = 16'h3000;
        mem[4] = 16'hC100; mem[5] = 16'h00AB; mem[6] = 16'h0400;
        mem[7] = 16'hC200; mem[8] = 16'h5555;
        mem[16'h0040] = 16'h0100;
        ws_mode     = 1'b0;
        wait_n      = 0;
        stall       = 1'b0;
        jump_taken  = 1'b0;
        jump_target = 16'h0000;
        reset       = 1'b0;

        test_reset();
        test_one_word();
        test_two_word();
        test_stall();
        test_jump();
        mem[16'hFFFF] = 16'hC300;
        mem[0]        = 16'h1234;
        test_wrap();
        test_waits_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end pipeline stage that produces the `instruction` word consumed by the decoding stage.
- Owns the PC and runs a request/valid handshake to instruction memory.
- Assembles two-word instructions (opword + 16-bit immediate word) before handing them to decode.
- Honours pipeline stall and jump redirect/flush from later stages.

Parameters:
- ADDR_WIDTH, 16, PC / instruction-memory address width.
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- IMM_MASK, 5'b11000, opcode bits examined to detect a two-word instruction.
- IMM_MATCH, 5'b11000, two-word when (opword[15:11] & IMM_MASK) == IMM_MATCH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request; imem_addr is valid while high.
- imem_addr  output  ADDR_WIDTH  word address being fetched.
- imem_data  input  16  returned word.
- imem_valid  input  1  imem_data valid; a transfer occurs only when imem_req && imem_valid.
- stall  input  1  decode cannot accept; output register must hold.
- jump_taken  input  1  redirect and flush request.
- jump_target  input  ADDR_WIDTH  new PC when jump_taken.
- instruction  output  16  opword to decode.
- immediate  output  16  immediate word; 0 for one-word instructions.
- instr_valid  output  1  instruction/immediate/pc_out are valid.
- pc_out  output  ADDR_WIDTH  address of the presented opword.
- next_pc  output  ADDR_WIDTH  address following the presented instruction (pc_out+1 or pc_out+2).

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_VECTOR; state=FETCH_OP.
  - instruction, immediate, pc_out, next_pc = 0; instr_valid=0.
  - opword holding register = 0; imem_req forced 0 while reset is low.
- States:
  - FETCH_OP: fetch opword.
  - FETCH_IMM: fetch immediate word.
- Output register is "free" when instr_valid=0 or stall=0.
- imem_req = free && !jump_taken (combinational, both states); imem_addr = pc.
- FETCH_OP, on transfer:
  - If the opword is two-word: latch opword, pc←pc+1, go to FETCH_IMM. Output register is unchanged.
  - Otherwise: instruction←imem_data, immediate←0, pc_out←pc, next_pc←pc+1, instr_valid←1, pc←pc+1; stay in FETCH_OP.
- FETCH_IMM, on transfer:
  - instruction←held opword, immediate←imem_data, pc_out←pc-1, next_pc←pc+1, instr_valid←1, pc←pc+1.
  - Go to FETCH_OP.
- A free cycle with no transfer: instr_valid←0 (bubble), other output fields unchanged.
- stall=1 with instr_valid=1: all outputs held; no request; FSM frozen.
  - A half-assembled two-word instruction stays in FETCH_IMM with the opword held.
- stall=1 with instr_valid=0: fetching continues normally (fills the empty slot).
- jump_taken=1 (priority over stall and over any transfer):
  - pc←jump_target; state←FETCH_OP; instr_valid←0.
  - Held opword discarded; imem_data in that cycle ignored.
  - Fetch from target begins the next cycle.
- Latency: a one-word instruction with 0-wait memory appears with instr_valid=1 on the edge after the transfer cycle.
  - Sustained throughput: 1 instr/cycle (one-word), 1 per 2 cycles (two-word).
- PC arithmetic is modulo 2^ADDR_WIDTH. A two-word instruction at 0xFFFF takes its immediate from 0x0000, with next_pc=0x0001.
- Memory wait states: imem_req stays high with a stable address until imem_valid, unless stall makes the slot non-free or jump_taken fires.
- No X propagation: imem_data is ignored when imem_valid=0.

Test Plan:
- Reset release, 0-wait memory, mem[0..2]=16'h0800,16'h1000,16'h2000 (one-word):
  - Required: instr_valid=1 on cycles 2,3,4.
  - instruction 0800/1000/2000; pc_out 0,1,2; next_pc 1,2,3.
- mem[4]=16'hC100 (two-word), mem[5]=16'h00AB:
  - Required: single presentation with instruction=C100, immediate=00AB, pc_out=4, next_pc=6.
  - instr_valid=0 during the immediate-fetch cycle.
- stall=1 for 3 cycles while instr_valid=1:
  - Required: outputs frozen; imem_req=0.
  - After release, the next instruction follows with no loss or duplication.
- jump_taken=1, target=16'h0040, asserted while in FETCH_IMM with a transfer in the same cycle:
  - Required: instr_valid=0 next cycle; imem_addr=0x0040.
  - The partial instruction is never presented.
- Two-word opword at 0xFFFF, immediate at 0x0000 = 16'h1234:
  - Required: pc_out=FFFF, immediate=1234, next_pc=0001.
- Memory with 2 wait states; reset deasserted then reasserted mid-FETCH_IMM:
  - Required: address held stable during the waits.
  - Reset immediately clears instr_valid and imem_req; pc=RESET_VECTOR.
